// File: rtl/reg_file_sb_pkg.sv
// Shared dimensions and types for the scoreboarded register file.
// Module parameters override the default-configuration values used here.
package reg_file_sb_pkg;

    localparam int num_regs       = 32;
    localparam int data_width     = 32;
    localparam int reg_sel_width  = $clog2(num_regs);
    localparam int busy_cnt_width = $clog2(num_regs + 1);

    typedef logic [reg_sel_width-1:0] reg_sel_t;
    typedef logic [data_width-1:0]    data_t;

    // Select width for an arbitrary register count, never narrower than 1 bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_busy_tracker.sv
// Per-register busy scoreboard: reservation grant, set/clear priority and a
// registered popcount of the busy vector.
module reg_busy_tracker
    import reg_file_sb_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int SEL_W    = sel_width(NUM_REGS),
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic                rsv_req,
    input  logic [SEL_W-1:0]    rsv_sel,
    output logic [NUM_REGS-1:0] busy,
    output logic                rsv_ack,
    output logic [CNT_W-1:0]    busy_count
);

    logic [NUM_REGS-1:0] busy_next;
    logic [CNT_W-1:0]    count_next;

    // A busy register can still be re-reserved when its writeback lands this cycle.
    assign rsv_ack = rsv_req &
                     ((rsv_sel == '0) | !busy[rsv_sel] | (wr_en & (wr_sel == rsv_sel)));

    // NOTE: combinational blocks assign a default first and use blocking '=' so
    // later statements can override earlier ones without inferring a latch.
    always_comb begin
        busy_next = busy;
        if (wr_en && (wr_sel != '0))
            busy_next[wr_sel] = 1'b0;
        // Reserve is applied after the clear so a same-cycle collision ends busy.
        if (rsv_ack && (rsv_sel != '0))
            busy_next[rsv_sel] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++)
            count_next = count_next + CNT_W'(busy_next[i]);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, one write port, optional
// write-to-read forwarding and a per-register busy scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter  int NUM_REGS       = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int NUM_READ_PORTS = 2,
    parameter  int BYPASS         = 1,
    localparam int SEL_W          = sel_width(NUM_REGS),
    localparam int CNT_W          = $clog2(NUM_REGS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ_PORTS*SEL_W-1:0]      rd_sel,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]            rd_busy,
    input  logic                                 wr_en,
    input  logic [SEL_W-1:0]                     wr_sel,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 rsv_req,
    input  logic [SEL_W-1:0]                     rsv_sel,
    output logic                                 rsv_ack,
    output logic [CNT_W-1:0]                     busy_count
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    reg_busy_tracker #(
        .NUM_REGS (NUM_REGS)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .rsv_req    (rsv_req),
        .rsv_sel    (rsv_sel),
        .busy       (busy),
        .rsv_ack    (rsv_ack),
        .busy_count (busy_count)
    );

    // NOTE: the data array is reset because architectural state must read as
    // zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_sel != '0)) begin
            regs[wr_sel] <= wr_data;
        end
    end

    always_comb begin
        logic [SEL_W-1:0] sel;
        sel     = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            sel = rd_sel[i*SEL_W +: SEL_W];
            if (sel != '0) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[sel];
                rd_busy[i]                          = busy[sel];
                // Forwarded write clears busy unless a granted reserve re-claims it.
                if ((BYPASS != 0) && wr_en && (wr_sel == sel)) begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                    rd_busy[i] = rsv_ack && (rsv_sel == sel);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a 32x32 two-port bypassing instance and an 8-entry
// four-port non-bypassing instance, both checked against an array model.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 32 regs, 2 ports, bypass on.
    logic [9:0]  a_rd_sel;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en, a_rsv_req, a_rsv_ack;
    logic [4:0]  a_wr_sel, a_rsv_sel;
    logic [31:0] a_wr_data;
    logic [5:0]  a_busy_count;

    // Instance B: 8 regs, 4 ports, bypass off.
    logic [11:0]  b_rd_sel;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_wr_en, b_rsv_req, b_rsv_ack;
    logic [2:0]   b_wr_sel, b_rsv_sel;
    logic [31:0]  b_wr_data;
    logic [3:0]   b_busy_count;

    reg_file_sb #(.NUM_REGS(32), .DATA_WIDTH(32), .NUM_READ_PORTS(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_sel(a_rd_sel), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_data(a_wr_data),
        .rsv_req(a_rsv_req), .rsv_sel(a_rsv_sel), .rsv_ack(a_rsv_ack),
        .busy_count(a_busy_count)
    );

    reg_file_sb #(.NUM_REGS(8), .DATA_WIDTH(32), .NUM_READ_PORTS(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_sel(b_rd_sel), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .rsv_req(b_rsv_req), .rsv_sel(b_rsv_sel), .rsv_ack(b_rsv_ack),
        .busy_count(b_busy_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural contents and reservation flags.
    logic [31:0] ra_regs [32];
    logic        ra_busy [32];
    logic [31:0] rb_regs [8];
    logic        rb_busy [8];

    function automatic logic exp_a_ack();
        return a_rsv_req && (a_rsv_sel == 0 || !ra_busy[a_rsv_sel] ||
                             (a_wr_en && a_wr_sel == a_rsv_sel));
    endfunction

    function automatic logic exp_b_ack();
        return b_rsv_req && (b_rsv_sel == 0 || !rb_busy[b_rsv_sel] ||
                             (b_wr_en && b_wr_sel == b_rsv_sel));
    endfunction

    function automatic logic [31:0] exp_a_data(input logic [4:0] sel);
        if (sel == 0) return 32'h0;
        if (a_wr_en && a_wr_sel == sel) return a_wr_data;
        return ra_regs[sel];
    endfunction

    function automatic logic exp_a_busy(input logic [4:0] sel);
        if (sel == 0) return 1'b0;
        if (a_wr_en && a_wr_sel == sel) return exp_a_ack() && (a_rsv_sel == sel);
        return ra_busy[sel];
    endfunction

    function automatic logic [31:0] exp_b_data(input logic [2:0] sel);
        return (sel == 0) ? 32'h0 : rb_regs[sel];
    endfunction

    function automatic logic exp_b_busy(input logic [2:0] sel);
        return (sel == 0) ? 1'b0 : rb_busy[sel];
    endfunction

    function automatic int cnt_a();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(ra_busy[i]);
        return n;
    endfunction

    function automatic int cnt_b();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(rb_busy[i]);
        return n;
    endfunction

    task automatic set_a(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                         input logic rq, input logic [4:0] rs,
                         input logic [4:0] r0, input logic [4:0] r1);
        a_wr_en = we; a_wr_sel = ws; a_wr_data = wd;
        a_rsv_req = rq; a_rsv_sel = rs; a_rd_sel = {r1, r0};
    endtask

    task automatic set_b(input logic we, input logic [2:0] ws, input logic [31:0] wd,
                         input logic rq, input logic [2:0] rs,
                         input logic [2:0] r0, input logic [2:0] r1,
                         input logic [2:0] r2, input logic [2:0] r3);
        b_wr_en = we; b_wr_sel = ws; b_wr_data = wd;
        b_rsv_req = rq; b_rsv_sel = rs; b_rd_sel = {r3, r2, r1, r0};
    endtask

    task automatic idle();
        set_a(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_b(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Advance one clock and apply the architectural rules to the model.
    task automatic clock();
        logic ack_a, ack_b;
        ack_a = exp_a_ack();
        ack_b = exp_b_ack();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin ra_regs[i] = 0; ra_busy[i] = 0; end
            for (int i = 0; i < 8; i++)  begin rb_regs[i] = 0; rb_busy[i] = 0; end
        end else begin
            if (a_wr_en && a_wr_sel != 0) begin
                ra_regs[a_wr_sel] = a_wr_data; ra_busy[a_wr_sel] = 1'b0;
            end
            if (ack_a && a_rsv_sel != 0) ra_busy[a_rsv_sel] = 1'b1;
            if (b_wr_en && b_wr_sel != 0) begin
                rb_regs[b_wr_sel] = b_wr_data; rb_busy[b_wr_sel] = 1'b0;
            end
            if (ack_b && b_rsv_sel != 0) rb_busy[b_rsv_sel] = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        clock();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 5'd5, 5'd7);
        clock();
        idle();
        a_rd_sel = {5'd7, 5'd5};
        settle();
        n_cmp++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF || a_rd_busy[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre: data %h busy %b, expected deadbeef busy 1",
                     a_rd_data[31:0], a_rd_busy[1]);
        end
        // Reset with a write and a reserve pending in the same cycle.
        set_a(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd9, 5'd5, 5'd7);
        rst = 1'b1;
        clock();
        rst = 1'b0;
        idle();
        a_rd_sel = {5'd7, 5'd5};
        settle();
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", a_rd_data[31:0]);
        end
        n_cmp++;
        if (a_rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 00", a_rd_busy);
        end
        n_cmp++;
        if (a_busy_count !== 6'd0 || b_busy_count !== 4'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d/%0d expected 0/0", a_busy_count, b_busy_count);
        end
        clock();
    endtask

    task automatic test_basic_rw();
        do_reset();
        set_a(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
        clock();
        set_a(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        clock();
        idle();
        a_rd_sel = {5'd0, 5'd3};
        settle();
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h12345678) begin
            n_bad++; $display("FAIL rw_r3: got %h expected 12345678", a_rd_data[31:0]);
        end
        n_cmp++;
        if (a_rd_data[63:32] !== 32'h0 || a_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL rw_r0: got %h busy %b expected 0 busy 0", a_rd_data[63:32], a_rd_busy[1]);
        end
        clock();
    endtask

    task automatic test_bypass();
        do_reset();
        set_b(1'b1, 3'd5, 32'h00001111, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        clock();
        set_a(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd9);
        set_b(1'b1, 3'd5, 32'hA5A5A5A5, 1'b0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0);
        settle();
        n_cmp++;
        if (a_rd_data[63:32] !== 32'hA5A5A5A5 || a_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL bypass_on: got %h busy %b expected a5a5a5a5 busy 0", a_rd_data[63:32], a_rd_busy[1]);
        end
        n_cmp++;
        if (b_rd_data[63:32] !== 32'h00001111) begin
            n_bad++; $display("FAIL bypass_off: got %h expected 00001111", b_rd_data[63:32]);
        end
        clock();
        idle();
        b_rd_sel = {3'd0, 3'd0, 3'd5, 3'd0};
        settle();
        n_cmp++;
        if (b_rd_data[63:32] !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL bypass_off_after: got %h expected a5a5a5a5", b_rd_data[63:32]);
        end
        clock();
    endtask

    task automatic test_scoreboard();
        do_reset();
        set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        settle();
        n_cmp++;
        if (a_rsv_ack !== 1'b1) begin
            n_bad++; $display("FAIL sb_ack1: got %b expected 1", a_rsv_ack);
        end
        clock();
        idle();
        a_rd_sel = {5'd0, 5'd4};
        settle();
        n_cmp++;
        if (a_rd_busy[0] !== 1'b1 || a_busy_count !== 6'd1) begin
            n_bad++; $display("FAIL sb_busy: got busy %b count %0d expected 1/1", a_rd_busy[0], a_busy_count);
        end
        set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        settle();
        n_cmp++;
        if (a_rsv_ack !== 1'b0) begin
            n_bad++; $display("FAIL sb_ack2: got %b expected 0", a_rsv_ack);
        end
        clock();
        set_a(1'b1, 5'd4, 32'h00000055, 1'b0, 5'd0, 5'd4, 5'd0);
        clock();
        idle();
        a_rd_sel = {5'd0, 5'd4};
        settle();
        n_cmp++;
        if (a_rd_busy[0] !== 1'b0 || a_busy_count !== 6'd0 || a_rd_data[31:0] !== 32'h55) begin
            n_bad++; $display("FAIL sb_clear: got busy %b count %0d data %h expected 0/0/55",
                              a_rd_busy[0], a_busy_count, a_rd_data[31:0]);
        end
        clock();
    endtask

    task automatic test_collision();
        do_reset();
        set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd0, 5'd0);
        clock();
        set_a(1'b1, 5'd6, 32'h00000077, 1'b1, 5'd6, 5'd6, 5'd0);
        settle();
        n_cmp++;
        if (a_rsv_ack !== 1'b1 || a_rd_data[31:0] !== 32'h77 || a_rd_busy[0] !== 1'b1) begin
            n_bad++; $display("FAIL coll_same_cycle: ack %b data %h busy %b expected 1/77/1",
                              a_rsv_ack, a_rd_data[31:0], a_rd_busy[0]);
        end
        clock();
        idle();
        a_rd_sel = {5'd0, 5'd6};
        settle();
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h77 || a_rd_busy[0] !== 1'b1 || a_busy_count !== 6'd1) begin
            n_bad++; $display("FAIL coll_after: data %h busy %b count %0d expected 77/1/1",
                              a_rd_data[31:0], a_rd_busy[0], a_busy_count);
        end
        clock();
    endtask

    task automatic test_full();
        int acks;
        do_reset();
        acks = 0;
        for (int r = 1; r < 32; r++) begin
            set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd0, 5'd0);
            if (r < 8) set_b(1'b0, 3'd0, 32'h0, 1'b1, 3'(r), 3'd0, 3'd0, 3'd0, 3'd0);
            else set_b(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
            settle();
            if (a_rsv_ack === 1'b1 && (r >= 8 || b_rsv_ack === 1'b1)) acks++;
            clock();
        end
        n_cmp++;
        if (acks != 31) begin
            n_bad++; $display("FAIL full_acks: got %0d expected 31", acks);
        end
        set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        set_b(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0);
        settle();
        n_cmp++;
        if (a_rsv_ack !== 1'b1 || b_rsv_ack !== 1'b1) begin
            n_bad++; $display("FAIL full_r0_ack: got %b/%b expected 1/1", a_rsv_ack, b_rsv_ack);
        end
        n_cmp++;
        if (b_rd_busy !== 4'b0111) begin
            n_bad++; $display("FAIL full_b_ports: got %b expected 0111", b_rd_busy);
        end
        clock();
        settle();
        n_cmp++;
        if (a_busy_count !== 6'd31 || b_busy_count !== 4'd7) begin
            n_bad++; $display("FAIL full_count: got %0d/%0d expected 31/7", a_busy_count, b_busy_count);
        end
        set_a(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0, 5'd0);
        settle();
        n_cmp++;
        if (a_rsv_ack !== 1'b0) begin
            n_bad++; $display("FAIL full_rsv_busy: got %b expected 0", a_rsv_ack);
        end
        clock();
    endtask

    task automatic test_random();
        logic [4:0] s0, s1;
        logic [2:0] t [4];
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            s0 = 5'($urandom_range(0, 31));
            s1 = 5'($urandom_range(0, 7));
            set_a(1'($urandom), 5'($urandom_range(0, ($urandom % 2) ? 31 : 7)), $urandom,
                  1'($urandom), 5'($urandom_range(0, ($urandom % 2) ? 31 : 7)), s0, s1);
            if ($urandom_range(0, 2) == 0) a_rd_sel[4:0] = a_wr_sel;
            for (int k = 0; k < 4; k++) t[k] = 3'($urandom_range(0, 7));
            set_b(1'($urandom), 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 3'($urandom_range(0, 7)), t[0], t[1], t[2], t[3]);
            settle();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (a_rd_data[p*32 +: 32] !== exp_a_data(a_rd_sel[p*5 +: 5]) ||
                    a_rd_busy[p] !== exp_a_busy(a_rd_sel[p*5 +: 5])) begin
                    n_bad++;
                    $display("FAIL rand_a_port%0d cyc %0d: got %h/%b expected %h/%b", p, n,
                             a_rd_data[p*32 +: 32], a_rd_busy[p],
                             exp_a_data(a_rd_sel[p*5 +: 5]), exp_a_busy(a_rd_sel[p*5 +: 5]));
                end
            end
            for (int p = 0; p < 4; p++) begin
                n_cmp++;
                if (b_rd_data[p*32 +: 32] !== exp_b_data(b_rd_sel[p*3 +: 3]) ||
                    b_rd_busy[p] !== exp_b_busy(b_rd_sel[p*3 +: 3])) begin
                    n_bad++;
                    $display("FAIL rand_b_port%0d cyc %0d: got %h/%b expected %h/%b", p, n,
                             b_rd_data[p*32 +: 32], b_rd_busy[p],
                             exp_b_data(b_rd_sel[p*3 +: 3]), exp_b_busy(b_rd_sel[p*3 +: 3]));
                end
            end
            n_cmp++;
            if (a_rsv_ack !== exp_a_ack() || b_rsv_ack !== exp_b_ack()) begin
                n_bad++; $display("FAIL rand_ack cyc %0d: got %b/%b expected %b/%b", n,
                                  a_rsv_ack, b_rsv_ack, exp_a_ack(), exp_b_ack());
            end
            n_cmp++;
            if (int'(a_busy_count) != cnt_a() || int'(b_busy_count) != cnt_b()) begin
                n_bad++; $display("FAIL rand_count cyc %0d: got %0d/%0d expected %0d/%0d", n,
                                  a_busy_count, b_busy_count, cnt_a(), cnt_b());
            end
            clock();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_basic_rw();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
